// File: rtl/i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// i2c_slave_regfile
//
// I2C target that exposes a small 8-bit register file on the SCL/SDA bus.
//   write : START, addr+W, offset, data, data, ..., STOP
//   read  : START, addr+W, offset, Sr, addr+R, data, ..., NACK, STOP
// A bare "START, addr+R" reads from the offset left by the previous access.
//
// SCL and SDA are oversampled on clk through 2-FF synchronizers. SCL is never
// stretched. SDA is sampled on the detected SCL rise. sda_drv_low changes only
// on the detected SCL fall, so SDA never moves while SCL is high.
//
// FSM state lives in state_q. It stays internal so that checkers can bind to it.
//
// Parameters
//   SLAVE_ADDR  7-bit bus address this block answers to
//   REG_NUM     register count, a power of 2 from 2 to 256
//
// Ports
//   clk         system clock; each SCL phase must last at least 4 clk
//   rst_n       asynchronous active-low reset
//   scl         bus clock from the master
//   sda         open-drain data line; this block only ever pulls it low
//   o_reg_data  last byte written into the register file
//   o_reg_addr  zero-extended offset of that last write
//   o_wr_done   1-clk pulse for each register written
//   o_rd_done   1-clk pulse for each byte sent, once the master ACK/NACK is sampled
//   o_busy      high from address match until STOP, START or address mismatch
// -----------------------------------------------------------------------------
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_NUM    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] o_reg_data,
    output logic [7:0] o_reg_addr,
    output logic       o_wr_done,
    output logic       o_rd_done,
    output logic       o_busy
);

    localparam int OW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        OFFSET,
        OFFSET_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_e;

    // Bus synchronizers. They reset to 1, which is the idle bus level.
    logic scl_s1_q, scl_s2_q, scl_d_q;
    logic sda_s1_q, sda_s2_q, sda_d_q;

    logic scl_rise, scl_fall, start_det, stop_det;

    state_e          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    // Holds the 7 bits received so far. On a read it holds the bits still to be sent.
    logic [6:0]      shift_q, shift_d;
    logic [OW-1:0]   offset_q, offset_d;
    logic            sda_drv_low_q, sda_drv_low_d;
    logic            busy_q, busy_d;
    logic            rw_q, rw_d;
    logic            wr_done_q, wr_done_d;
    logic            rd_done_q, rd_done_d;
    logic [7:0]      reg_data_q, reg_data_d;
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      regs_q [REG_NUM];
    logic [7:0]      regs_d [REG_NUM];

    logic [7:0]      byte_in;
    logic [7:0]      rd_byte;
    logic [OW-1:0]   offset_inc;

    assign sda = sda_drv_low_q ? 1'b0 : 1'bz;

    assign scl_rise  = scl_s2_q & ~scl_d_q;
    assign scl_fall  = ~scl_s2_q & scl_d_q;
    // A START or STOP needs SCL high in both the current and the previous
    // sample. SDA moving right next to an SCL edge is therefore never
    // mistaken for a bus condition.
    assign start_det = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;

    assign o_reg_data = reg_data_q;
    assign o_reg_addr = reg_addr_q;
    assign o_wr_done  = wr_done_q;
    assign o_rd_done  = rd_done_q;
    assign o_busy     = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_d_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_d_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_d_q  <= scl_s2_q;
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            sda_d_q  <= sda_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            offset_q      <= '0;
            sda_drv_low_q <= 1'b0;
            busy_q        <= 1'b0;
            rw_q          <= 1'b0;
            wr_done_q     <= 1'b0;
            rd_done_q     <= 1'b0;
            reg_data_q    <= '0;
            reg_addr_q    <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            offset_q      <= offset_d;
            sda_drv_low_q <= sda_drv_low_d;
            busy_q        <= busy_d;
            rw_q          <= rw_d;
            wr_done_q     <= wr_done_d;
            rd_done_q     <= rd_done_d;
            reg_data_q    <= reg_data_d;
            reg_addr_q    <= reg_addr_d;
            regs_q        <= regs_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        offset_d      = offset_q;
        sda_drv_low_d = sda_drv_low_q;
        busy_d        = busy_q;
        rw_d          = rw_q;
        wr_done_d     = 1'b0;
        rd_done_d     = 1'b0;
        reg_data_d    = reg_data_q;
        reg_addr_d    = reg_addr_q;
        regs_d        = regs_q;

        byte_in    = {shift_q, sda_s2_q};
        rd_byte    = regs_q[offset_q];
        // The offset is a power-of-2 width, so the +1 wraps naturally from REG_NUM-1 to 0.
        offset_inc = offset_q + OW'(1);

        if (start_det) begin
            state_d       = ADDR;
            bit_cnt_d     = '0;
            sda_drv_low_d = 1'b0;
            busy_d        = 1'b0;
        end else if (stop_det) begin
            state_d       = IDLE;
            bit_cnt_d     = '0;
            sda_drv_low_d = 1'b0;
            busy_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE, WAIT_STOP: begin
                    // Only a START or STOP leaves these states.
                end

                // bit_cnt reaches 8 on the 8th rise. The ACK is then driven on
                // the following fall, so it is stable for the 9th SCL high phase.
                ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                busy_d = 1'b1;
                                rw_d   = byte_in[0];
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_drv_low_d = 1'b1;
                        state_d       = ADDR_ACK;
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (!rw_q) begin
                            sda_drv_low_d = 1'b0;
                            state_d       = OFFSET;
                        end else begin
                            shift_d       = rd_byte[6:0];
                            sda_drv_low_d = ~rd_byte[7];
                            state_d       = RD_DATA;
                        end
                    end
                end

                OFFSET: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            offset_d = byte_in[OW-1:0];
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_drv_low_d = 1'b1;
                        state_d       = OFFSET_ACK;
                    end
                end

                OFFSET_ACK: begin
                    if (scl_fall) begin
                        sda_drv_low_d = 1'b0;
                        bit_cnt_d     = '0;
                        state_d       = WR_DATA;
                    end
                end

                // The register is written only on the 8th rise. A byte cut short
                // by a START or STOP therefore never reaches the register file.
                WR_DATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            regs_d[offset_q] = byte_in;
                            reg_data_d       = byte_in;
                            reg_addr_d       = 8'(offset_q);
                            wr_done_d        = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_drv_low_d = 1'b1;
                        state_d       = WR_ACK;
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        sda_drv_low_d = 1'b0;
                        offset_d      = offset_inc;
                        bit_cnt_d     = '0;
                        state_d       = WR_DATA;
                    end
                end

                // bit_cnt counts the bits already sent. Bit 7 is driven on entry,
                // and each fall moves on to the next bit. The fall after bit 0
                // releases SDA so the master can ACK.
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_drv_low_d = 1'b0;
                            bit_cnt_d     = '0;
                            state_d       = RD_ACK;
                        end else begin
                            sda_drv_low_d = ~shift_q[6];
                            shift_d       = {shift_q[5:0], 1'b0};
                            bit_cnt_d     = bit_cnt_q + 4'd1;
                        end
                    end
                end

                // A NACK leaves on the rise. The only fall seen here therefore
                // follows an ACK, and it starts the next byte.
                RD_ACK: begin
                    if (scl_rise) begin
                        rd_done_d = 1'b1;
                        offset_d  = offset_inc;
                        if (sda_s2_q) begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        shift_d       = rd_byte[6:0];
                        sda_drv_low_d = ~rd_byte[7];
                        bit_cnt_d     = '0;
                        state_d       = RD_DATA;
                    end
                end

                default: begin
                    state_d       = IDLE;
                    sda_drv_low_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_regfile
//
// Bus-level bench for i2c_slave_regfile. It acts as the I2C master and keeps a
// reference copy of the register file and offset. Expected register commits
// and read bytes are queued when the stimulus is issued. They are popped and
// compared when the DUT produces the commit pulse or the read byte.
// -----------------------------------------------------------------------------
module tb_i2c_slave_regfile;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda_low;
    wire        sda;
    logic [7:0] o_reg_data;
    logic [7:0] o_reg_addr;
    logic       o_wr_done;
    logic       o_rd_done;
    logic       o_busy;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_regfile #(
        .SLAVE_ADDR (7'h50),
        .REG_NUM    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl        (m_scl),
        .sda        (sda),
        .o_reg_data (o_reg_data),
        .o_reg_addr (o_reg_addr),
        .o_wr_done  (o_wr_done),
        .o_rd_done  (o_rd_done),
        .o_busy     (o_busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mem_m [16];
    logic [3:0]  off_m;
    logic [15:0] wr_exp_q [$];
    logic [7:0]  rd_exp_q [$];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    bit          busy_seen  = 1'b0;
    bit          drive_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Monitor samples 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (o_wr_done) begin
            wr_cnt++;
            if (wr_exp_q.size() == 0) begin
                check_eq("wr_unexpected", 32'(o_wr_done), 32'd0);
            end else begin
                check_eq("wr_commit", 32'({o_reg_addr, o_reg_data}), 32'(wr_exp_q.pop_front()));
            end
        end
        if (o_rd_done) rd_cnt++;
        if (o_busy) busy_seen = 1'b1;
        if (!m_sda_low && sda === 1'b0) drive_seen = 1'b1;
    end

    // ---------------- master driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        m_scl     = 1'b1;
        tick(8);
        m_sda_low = 1'b1;
        tick(8);
        m_scl = 1'b0;
    endtask

    task automatic i2c_rep_start();
        tick(2);
        m_sda_low = 1'b0;
        tick(6);
        m_scl = 1'b1;
        tick(8);
        m_sda_low = 1'b1;
        tick(8);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(2);
        m_sda_low = 1'b1;
        tick(6);
        m_scl = 1'b1;
        tick(8);
        m_sda_low = 1'b0;
        tick(8);
    endtask

    task automatic send_bit(input logic b);
        tick(2);
        m_sda_low = ~b;
        tick(6);
        m_scl = 1'b1;
        tick(8);
        m_scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        tick(2);
        m_sda_low = 1'b0;
        tick(6);
        m_scl = 1'b1;
        tick(4);
        b = (sda === 1'b0) ? 1'b0 : 1'b1;
        tick(4);
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_bit(ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            get_bit(bt);
            b[i] = bt;
        end
        send_bit(nack);
    endtask

    // ---------------- transaction tasks ----------------
    task automatic txn_write(input logic [7:0] off, input int n, input logic [7:0] d0,
                             input logic [7:0] d1);
        logic       a;
        logic [7:0] d;
        int         w0;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a);
        check_eq("wr_ack_addr", 32'(a), 32'd0);
        send_byte(off, a);
        check_eq("wr_ack_off", 32'(a), 32'd0);
        off_m = off[3:0];
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : d1;
            wr_exp_q.push_back({4'h0, off_m, d});
            mem_m[off_m] = d;
            off_m = off_m + 4'd1;
            send_byte(d, a);
            check_eq("wr_ack_data", 32'(a), 32'd0);
        end
        i2c_stop();
        tick(4);
        check_eq("wr_count", 32'(wr_cnt - w0), 32'(n));
        check_eq("wr_busy_after_stop", 32'(o_busy), 32'd0);
    endtask

    task automatic txn_read(input logic [7:0] off, input int n);
        logic       a;
        logic [7:0] b;
        int         r0;
        r0 = rd_cnt;
        i2c_start();
        send_byte(8'hA0, a);
        check_eq("rd_ack_addr_w", 32'(a), 32'd0);
        send_byte(off, a);
        check_eq("rd_ack_off", 32'(a), 32'd0);
        off_m = off[3:0];
        i2c_rep_start();
        send_byte(8'hA1, a);
        check_eq("rd_ack_addr_r", 32'(a), 32'd0);
        for (int k = 0; k < n; k++) begin
            rd_exp_q.push_back(mem_m[off_m]);
            off_m = off_m + 4'd1;
            recv_byte(k == n - 1, b);
            check_eq("rd_data", 32'(b), 32'(rd_exp_q.pop_front()));
        end
        i2c_stop();
        tick(4);
        check_eq("rd_count", 32'(rd_cnt - r0), 32'(n));
        check_eq("rd_busy_after_stop", 32'(o_busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic       a;
        logic [7:0] b;
        logic [7:0] r_off, r_dat;
        int         w0, r0;

        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        off_m     = 4'd0;
        rst_n     = 1'b0;
        m_scl     = 1'b1;
        m_sda_low = 1'b0;
        tick(4);
        check_eq("reset_outputs", 32'({o_reg_data, o_reg_addr, o_wr_done, o_rd_done, o_busy}), 32'd0);
        check_eq("reset_sda_released", 32'(sda !== 1'b0), 32'd1);
        rst_n = 1'b1;
        tick(8);

        // Single write, then a random read of the same register.
        txn_write(8'h03, 1, 8'hA5, 8'h00);
        check_eq("t1_reg_data", 32'(o_reg_data), 32'hA5);
        check_eq("t1_reg_addr", 32'(o_reg_addr), 32'h03);
        txn_read(8'h03, 1);

        // Burst write across the top of the register file.
        txn_write(8'h0F, 2, 8'h11, 8'h22);
        check_eq("t2_reg_addr", 32'(o_reg_addr), 32'h00);
        txn_read(8'h0F, 2);

        // Another address: no ACK, no drive, no busy, no write.
        busy_seen  = 1'b0;
        drive_seen = 1'b0;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA2, a);
        check_eq("t4_nack_addr", 32'(a), 32'd1);
        send_byte(8'h03, a);
        check_eq("t4_nack_off", 32'(a), 32'd1);
        send_byte(8'h77, a);
        check_eq("t4_nack_data", 32'(a), 32'd1);
        i2c_stop();
        tick(4);
        check_eq("t4_busy_seen", 32'(busy_seen), 32'd0);
        check_eq("t4_sda_driven", 32'(drive_seen), 32'd0);
        check_eq("t4_wr_count", 32'(wr_cnt - w0), 32'd0);
        txn_read(8'h03, 1);

        // Random writes and read-backs. Offsets above 15 also exercise the wrap to REG_NUM.
        for (int r = 0; r < 4; r++) begin
            r_off = 8'($urandom_range(0, 255));
            r_dat = 8'($urandom_range(0, 255));
            txn_write(r_off, 1, r_dat, 8'h00);
            txn_read(r_off, 1);
        end

        // Reset asserted in the high phase of data bit 4.
        i2c_start();
        send_byte(8'hA0, a);
        check_eq("t5_ack_addr", 32'(a), 32'd0);
        send_byte(8'h04, a);
        check_eq("t5_ack_off", 32'(a), 32'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        tick(2);
        m_sda_low = 1'b0;
        tick(6);
        m_scl = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check_eq("t5_sda_released", 32'(sda !== 1'b0), 32'd1);
        check_eq("t5_outputs_zero", 32'({o_reg_data, o_reg_addr, o_wr_done, o_rd_done, o_busy}), 32'd0);
        tick(8);
        rst_n = 1'b1;
        tick(8);
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        off_m = 4'd0;
        check_eq("t5_no_pending_write", 32'(wr_exp_q.size()), 32'd0);
        txn_read(8'h03, 1);
        txn_write(8'h04, 1, 8'h3C, 8'h00);
        txn_read(8'h04, 1);

        // A partial data byte followed by Sr must not write. The read returns the old reg[5].
        txn_write(8'h05, 1, 8'h96, 8'h00);
        w0 = wr_cnt;
        r0 = rd_cnt;
        i2c_start();
        send_byte(8'hA0, a);
        check_eq("t6_ack_addr", 32'(a), 32'd0);
        send_byte(8'h05, a);
        check_eq("t6_ack_off", 32'(a), 32'd0);
        off_m = 4'd5;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_rep_start();
        send_byte(8'hA1, a);
        check_eq("t6_ack_addr_r", 32'(a), 32'd0);
        rd_exp_q.push_back(mem_m[off_m]);
        recv_byte(1'b1, b);
        check_eq("t6_rd_data", 32'(b), 32'(rd_exp_q.pop_front()));
        i2c_stop();
        tick(4);
        check_eq("t6_wr_count", 32'(wr_cnt - w0), 32'd0);
        check_eq("t6_rd_count", 32'(rd_cnt - r0), 32'd1);

        check_eq("end_wr_queue", 32'(wr_exp_q.size()), 32'd0);
        check_eq("end_rd_queue", 32'(rd_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
